mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
Serialises the up-to-two load/store requests of one issue bundle onto the single-port data Memory in program order.
- Lane 0 is the older instruction and is always serviced first.
- Holds the bundle in the Mem stage with a stall until both accesses complete.
- Returns per-lane read data and a misalignment error to the writeback path.
- Sits between the Mem-stage pipeline registers and the data Memory; its stall output feeds the Hazard Unit.

Parameters:
WIDTH, 32, data/address width
MEM_LATENCY, 2, cycles a load holds the memory read strobe before read data is valid (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_valid  in  2  per-lane memory request present in Mem stage
req_we  in  2  per-lane 1=store, 0=load
req_size  in  2x2  per-lane 00 byte, 01 half, 10 word (11 treated as word)
req_addr  in  2xWIDTH  per-lane byte address
req_wdata  in  2xWIDTH  per-lane store data
stall_mem  out  1  hold Fetch..Mem stages this cycle
resp_valid  out  2  per-lane response pulse (DONE cycle)
resp_rdata  out  2xWIDTH  per-lane load data (0 for stores/errors)
resp_err  out  2  per-lane misaligned access
mem_read_en  out  1  memory read strobe
mem_write_en  out  1  memory write strobe
mem_size  out  2  access size to memory
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data

Behaviour:
- Reset (rst==0 at posedge), including mid-operation:
  - state=IDLE, counter=0, captured slots cleared.
  - All outputs 0; an in-flight strobe drops at that edge.
- FSM states: IDLE, SLOT0, SLOT1, DONE.
- IDLE:
  - stall_mem = |req_valid (combinational).
  - If any req_valid: capture both lanes into internal slot registers.
  - Next state: SLOT0 if req_valid[0], else SLOT1.
- Misalignment:
  - Half with addr[0]=1 is misaligned; word with addr[1:0]≠0 is misaligned.
  - A misaligned slot lasts 1 cycle with no memory strobe and sets its err flag.
- Slot timing:
  - Store slot: mem_write_en=1 for exactly 1 cycle.
  - Load slot: mem_read_en=1 for MEM_LATENCY cycles. mem_rdata is sampled into resp data at the end of the last cycle.
  - mem_size/mem_addr/mem_wdata are driven from the active slot's registers for the whole slot; they are 0 when no slot is active.
- SLOT0 completion → SLOT1 if slot1 valid, else DONE. SLOT1 completion → DONE.
- Stall window: stall_mem=1 in SLOT0/SLOT1.
- DONE:
  - stall_mem=0; resp_valid = captured valid mask for exactly 1 cycle; resp_rdata/resp_err valid.
  - req_* is ignored this cycle (it still shows the finished bundle).
  - Next state IDLE.
- Latency, load-only single lane: stall for 1+MEM_LATENCY cycles; DONE at cycle MEM_LATENCY+1 after the accept cycle.
- Latency, two loads: stall for 1+2·MEM_LATENCY cycles.
- Same address in both lanes: lane 1 observes or overwrites lane 0's effect, because order is strict.
- Internal counter is $clog2(MEM_LATENCY+1) bits; it resets at each slot start and never wraps.
- resp_rdata holds its value outside DONE but is only meaningful while resp_valid=1.

Decomposition:
- Shared package:
  - mem_size_t enum (BYTE/HALF/WORD).
  - seq_state_t enum (IDLE/SLOT0/SLOT1/DONE).
  - mem_slot_t struct {valid, we, size, addr, wdata}.
  - MEM_LATENCY default constant.
- One natural sub-module: mem_align_check.
  - Combinational; size and addr[1:0] in → misaligned out.
  - Instantiated once per lane at capture.

Test Plan:
1. Lane0 load word 0x100 (mem holds 0xDEADBEEF), lane1 idle, MEM_LATENCY=2 → stall_mem high 3 cycles, mem_read_en 2 cycles, resp_valid=2'b01, resp_rdata[0]=0xDEADBEEF, stall low in DONE.
2. Lane0 store word 0x200←0x11111111, lane1 load word 0x200 → one write pulse then 2 read cycles; resp_rdata[1]=0x11111111; stall 4 cycles.
3. Both lanes store word to 0x300 (0xA, then 0xB) → two single-cycle writes in lane order; a subsequent load of 0x300 returns 0xB.
4. Lane0 load half at 0x101, lane1 load byte 0x104 → lane0 skipped with no strobe, resp_err=2'b01, lane1 data correct, total stall 1+1+2=4 cycles.
5. rst low during SLOT1 of a two-load bundle → next cycle state IDLE, all strobes/stall/resp 0; a re-presented bundle is then fully serviced.
6. req_valid=2'b00 → stall_mem never asserts, no strobes; back-to-back bundles → IDLE accept occurs one cycle after DONE, with no duplicate service of the old bundle.

Source files
------------

// File: rtl/mem_port_sequencer_pkg.sv
// Shared types for the Mem-stage load/store sequencer: access sizes, FSM states
// and the captured per-lane request slot.
package mem_port_sequencer_pkg;

  localparam int MEM_LATENCY_DEFAULT = 2;
  // Slot address/data fields are this wide; the sequencer's WIDTH must not exceed it.
  localparam int SLOT_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SLOT0 = 2'b01,
    ST_SLOT1 = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    mem_size_t             size;
    logic [SLOT_WIDTH-1:0] addr;
    logic [SLOT_WIDTH-1:0] wdata;
  } mem_slot_t;

  // The unused 2'b11 encoding is folded onto a word access.
  function automatic mem_size_t norm_size(input logic [1:0] raw);
    case (raw)
      2'b00:   norm_size = SZ_BYTE;
      2'b01:   norm_size = SZ_HALF;
      default: norm_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_sequencer_align_check.sv
// Natural-alignment check for one lane: halves need addr[0]==0, words need
// addr[1:0]==0, bytes are always aligned.
module mem_align_check
  import mem_port_sequencer_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (norm_size(size))
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// Serialises the two load/store lanes of an issue bundle onto one memory port,
// lane 0 first, stalling the front of the pipeline until both lanes finish.
module mem_port_sequencer
  import mem_port_sequencer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_we,
  input  logic [3:0]         req_size,
  input  logic [2*WIDTH-1:0] req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic               stall_mem,
  output logic [1:0]         resp_valid,
  output logic [2*WIDTH-1:0] resp_rdata,
  output logic [1:0]         resp_err,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [1:0]         mem_size,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_slot_t        slot_q [2];
  mem_slot_t        slot_d [2];
  logic [WIDTH-1:0] rdata_q [2];
  logic [WIDTH-1:0] rdata_d [2];
  logic [1:0]       err_q, err_d;
  logic [1:0]       mis;
  logic             lane;
  logic             slot_done;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    mem_align_check u_align (
      .size       (req_size[2*i +: 2]),
      .addr_lo    (req_addr[i*WIDTH +: 2]),
      .misaligned (mis[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int i = 0; i < 2; i++) begin
        slot_q[i]  <= slot_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  // Handshake: a bundle is accepted in IDLE whenever req_valid is non-zero;
  // the pipeline holds it while stall_mem=1 and advances on the DONE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    lane         = 1'b0;
    slot_done    = 1'b0;
    stall_mem    = 1'b0;
    resp_valid   = 2'b00;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_size     = 2'b00;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        stall_mem = rst & (|req_valid);
        if (|req_valid) begin
          for (int i = 0; i < 2; i++) begin
            slot_d[i].valid = req_valid[i];
            slot_d[i].we    = req_we[i];
            slot_d[i].size  = norm_size(req_size[2*i +: 2]);
            slot_d[i].addr  = SLOT_WIDTH'(req_addr[i*WIDTH +: WIDTH]);
            slot_d[i].wdata = SLOT_WIDTH'(req_wdata[i*WIDTH +: WIDTH]);
            rdata_d[i]      = '0;
            err_d[i]        = req_valid[i] & mis[i];
          end
          cnt_d   = '0;
          state_d = req_valid[0] ? ST_SLOT0 : ST_SLOT1;
        end
      end

      ST_SLOT0, ST_SLOT1: begin
        stall_mem = 1'b1;
        lane      = (state_q == ST_SLOT1);
        mem_size  = slot_q[lane].size;
        mem_addr  = slot_q[lane].addr[WIDTH-1:0];
        mem_wdata = slot_q[lane].wdata[WIDTH-1:0];
        if (err_q[lane]) begin
          slot_done = 1'b1;
        end else if (slot_q[lane].we) begin
          mem_write_en = 1'b1;
          slot_done    = 1'b1;
        end else begin
          mem_read_en = 1'b1;
          if (cnt_q == LAST_CNT) begin
            slot_done     = 1'b1;
            rdata_d[lane] = mem_rdata;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (slot_done) begin
          cnt_d   = '0;
          state_d = (state_q == ST_SLOT0 && slot_q[1].valid) ? ST_SLOT1 : ST_DONE;
        end
      end

      ST_DONE: begin
        resp_valid = {slot_q[1].valid, slot_q[0].valid};
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = {rdata_q[1], rdata_q[0]};
  assign resp_err   = (state_q == ST_DONE) ? err_q : 2'b00;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: a word-addressed memory model answers
// the port, and every bundle's stall/strobe profile and responses are checked.
module tb_mem_port_sequencer;
  import mem_port_sequencer_pkg::*;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_we;
  logic [3:0]         req_size;
  logic [2*WIDTH-1:0] req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic               stall_mem;
  logic [1:0]         resp_valid;
  logic [2*WIDTH-1:0] resp_rdata;
  logic [1:0]         resp_err;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [1:0]         mem_size;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;
  logic [1:0]         dbg_state;

  mem_port_sequencer #(.WIDTH(WIDTH), .MEM_LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall_mem    (stall_mem),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model, updated mid-cycle of each write strobe
  logic [WIDTH-1:0] mem [0:255];
  assign mem_rdata = mem_read_en ? mem[mem_addr[9:2]] : '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h41] = 32'h0000_00C3;
    forever begin
      @(negedge clk);
      if (mem_write_en) mem[mem_addr[9:2]] = mem_wdata;
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-bundle observations
  int                 n_stall, n_rd, n_wr, done_c, first_rd_c, first_wr_c;
  logic               got_done, first_stall, done_stall;
  logic [1:0]         cap_valid, cap_err;
  logic [2*WIDTH-1:0] cap_rdata;

  // Drive: called just after a posedge; returns just after the DONE edge.
  task automatic run_bundle(input logic [1:0] v, input logic [1:0] we, input logic [3:0] sz,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
    n_stall = 0; n_rd = 0; n_wr = 0; done_c = -1; first_rd_c = -1; first_wr_c = -1;
    got_done = 1'b0; first_stall = 1'b0; done_stall = 1'b1;
    cap_valid = '0; cap_err = '0; cap_rdata = '0;
    req_valid = v; req_we = we; req_size = sz;
    req_addr = {a1, a0}; req_wdata = {d1, d0};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) first_stall = stall_mem;
      if (stall_mem) n_stall++;
      if (mem_read_en) begin
        n_rd++;
        if (first_rd_c < 0) first_rd_c = c;
      end
      if (mem_write_en) begin
        n_wr++;
        if (first_wr_c < 0) first_wr_c = c;
        if (exp_q.size() == 0) check_eq("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
        else check_eq("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      if (resp_valid != 2'b00) begin
        got_done = 1'b1; done_c = c; cap_valid = resp_valid;
        cap_err = resp_err; cap_rdata = resp_rdata; done_stall = stall_mem;
      end
      @(posedge clk); #1;
      if (got_done) break;
    end
    req_valid = 2'b00;
    check_eq("done_seen", {63'd0, got_done}, 64'd1);
    check_eq("writes_left", exp_q.size(), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_size = 4'b1010;
    req_addr = {32'h104, 32'h100}; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_stall", stall_mem, 0);
    check_eq("rst_strobes", {mem_read_en, mem_write_en}, 0);
    check_eq("rst_resp", {resp_valid, resp_err}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;

    // T1: lane0 load word 0x100
    run_bundle(2'b01, 2'b00, 4'b0010, 32'h100, 32'h0, 32'h0, 32'h0);
    check_eq("t1_stall", n_stall, 3);
    check_eq("t1_reads", n_rd, 2);
    check_eq("t1_writes", n_wr, 0);
    check_eq("t1_done_cycle", done_c, 3);
    check_eq("t1_valid", cap_valid, 2'b01);
    check_eq("t1_rdata0", cap_rdata[31:0], 32'hDEAD_BEEF);
    check_eq("t1_err", cap_err, 2'b00);
    check_eq("t1_done_stall", done_stall, 0);

    // T2: lane0 store 0x200, lane1 load 0x200
    exp_q.push_back({32'h200, 32'h1111_1111});
    run_bundle(2'b11, 2'b01, 4'b1010, 32'h200, 32'h200, 32'h1111_1111, 32'h0);
    check_eq("t2_stall", n_stall, 4);
    check_eq("t2_reads", n_rd, 2);
    check_eq("t2_first_wr", first_wr_c, 1);
    check_eq("t2_first_rd", first_rd_c, 2);
    check_eq("t2_valid", cap_valid, 2'b11);
    check_eq("t2_rdata", cap_rdata, {32'h1111_1111, 32'h0});

    // T3: both lanes store 0x300, then a back-to-back load sees lane1's value
    exp_q.push_back({32'h300, 32'hA});
    exp_q.push_back({32'h300, 32'hB});
    run_bundle(2'b11, 2'b11, 4'b1010, 32'h300, 32'h300, 32'hA, 32'hB);
    check_eq("t3_stall", n_stall, 3);
    check_eq("t3_writes", n_wr, 2);
    check_eq("t3_reads", n_rd, 0);
    check_eq("t3_rdata", cap_rdata, 64'h0);
    run_bundle(2'b01, 2'b00, 4'b0010, 32'h300, 32'h0, 32'h0, 32'h0);
    check_eq("t3b_accept_stall", first_stall, 1);
    check_eq("t3b_done_cycle", done_c, 3);
    check_eq("t3b_writes", n_wr, 0);
    check_eq("t3b_rdata0", cap_rdata[31:0], 32'hB);

    // T4: lane0 misaligned half at 0x101, lane1 byte at 0x104
    run_bundle(2'b11, 2'b00, 4'b0001, 32'h101, 32'h104, 32'h0, 32'h0);
    check_eq("t4_stall", n_stall, 4);
    check_eq("t4_first_rd", first_rd_c, 2);
    check_eq("t4_reads", n_rd, 2);
    check_eq("t4_err", cap_err, 2'b01);
    check_eq("t4_valid", cap_valid, 2'b11);
    check_eq("t4_rdata", cap_rdata, {32'h0000_00C3, 32'h0});

    // T5: reset during SLOT1 of a two-load bundle, then re-present
    req_valid = 2'b11; req_we = 2'b00; req_size = 4'b1010;
    req_addr = {32'h104, 32'h100};
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("t5_in_slot1", dbg_state, ST_SLOT1);
    check_eq("t5_slot1_read", mem_read_en, 1);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_rst_state", dbg_state, ST_IDLE);
    check_eq("t5_rst_outs", {stall_mem, mem_read_en, mem_write_en, resp_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_bundle(2'b11, 2'b00, 4'b1010, 32'h100, 32'h104, 32'h0, 32'h0);
    check_eq("t5_stall", n_stall, 5);
    check_eq("t5_reads", n_rd, 4);
    check_eq("t5_rdata", cap_rdata, {32'h0000_00C3, 32'hDEAD_BEEF});

    // T6: no requests -> no stall, no strobes
    n_stall = 0; n_rd = 0; n_wr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (stall_mem) n_stall++;
      if (mem_read_en) n_rd++;
      if (mem_write_en) n_wr++;
    end
    check_eq("t6_idle_activity", {n_stall[15:0], n_rd[15:0], n_wr[15:0]}, 0);
    check_eq("t6_state", dbg_state, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
